stf_gen: RTL
============

// Module: stf_gen
// PURPOSE
//  TX-side 802.11a/g short training field (STF) generator: counterpart of the RX short-preamble detector.
//  On a start pulse, streams NUM_REPS repetitions of the 16-sample time-domain short symbol as 32-bit IQ.
//  Format is {I[31:16], Q[15:0]}, signed, 1.0 = 8192. Sits at the head of the TX chain, ahead of the LTF generator and IFFT output mux.
// PARAMETERS
//  NUM_REPS   10  short-symbol repetitions per field (1..15); 10 -> 160 samples
//  WINDOW_EN  1   1: halve the first sample of the field (802.11 w(0)=0.5 edge window)
// PORTS
//  clock              in   1   system clock
//  reset              in   1   synchronous, active-high
//  enable             in   1   clock enable; low freezes all state
//  start              in   1   single-cycle pulse: begin one STF field
//  gain_shift         in   2   arithmetic right shift applied to I and Q (0..3); sampled at start
//  sample_out_ready   in   1   downstream accepts the current sample
//  sample_out         out  32  {I,Q} sample
//  sample_out_strobe  out  1   sample_out valid (held until accepted)
//  busy               out  1   field in progress
//  done               out  1   one-cycle pulse after the final sample is accepted
// BEHAVIOUR
//  Reset: sample_out=0, sample_out_strobe=0, busy=0, done=0, state=IDLE, sym_idx=0, rep_cnt=0.
//  FSM (all transitions qualified by enable):
//   IDLE -> RUN on start; latch gain_shift; sym_idx=0, rep_cnt=0; busy=1.
//   RUN: on transfer (strobe & ready), advance sym_idx (4 bit, wraps 15->0).
//     rep_cnt increments on the wrap.
//   RUN -> DONE on the transfer with rep_cnt==NUM_REPS-1 and sym_idx==15.
//   DONE: done=1, busy=0, strobe=0 for one cycle -> IDLE.
//  Latency: start accepted in cycle N -> strobe=1 with sample 0 in cycle N+1 (registered ROM read).
//  Handshake: valid/ready. While strobe=1 and ready=0, sample_out is held stable.
//   Back-to-back transfers are sustained at 1 sample/clock when ready=1.
//  Datapath per component: x = ROM[sym_idx] >>> gain_shift.
//   If WINDOW_EN and this is field sample 0: x = x >>> 1 (gain first, then window).
//   Arithmetic shift, rounding toward -inf; no saturation is needed.
//  ROM word k = round(8192*s(k)) of the IEEE 802.11 STF time samples.
//   e.g. ROM[0]={377,377}, ROM[1]={-1081,16}.
//  Boundary conditions:
//   - start while busy or in DONE: ignored.
//   - start coincident with reset: reset wins.
//   - enable=0: strobe forced 0, no state or index change. On re-enable, the same pending sample is re-presented.
//   - reset mid-field: next cycle strobe=0, busy=0, no done pulse. Partial field is abandoned.
//   - gain_shift changes mid-field: no effect until next start.
// STRUCTURE
//  Shared package/common_defs: STF_SYM_LEN=16, IQ_WIDTH=16, the 16-entry STF_ROM table constants.
//  Sub-module stf_rom: 16x32 registered case-ROM (addr in, data out one cycle later).
//  Top contains the FSM, counters, gain/window shifter and output register.
// TESTING
//  1. start, ready=1, gain_shift=0:
//     - exactly 160 consecutive strobes;
//     - sample k == ROM[k%16] for k>=1; sample 0 == {188,188};
//     - done one cycle after the 160th transfer.
//  2. ready toggling 1/0 each cycle: sample_out stable while ready=0; 160 transfers in order; busy=1 throughout.
//  3. gain_shift=2: sample 0 == {47,47}; sample 1 == {-271,4}; sample 17 == {-271,4}.
//  4. Reset at transfer 50: strobe=0 and busy=0 next cycle, no done. Fresh start restarts at sample 0 == {188,188}.
//  5. start pulsed while busy: ignored, field length stays 160. enable low 5 cycles mid-field: no strobes, resumes at the same index.
//  6. Loopback into the RX short-preamble detector (min_plateau=100, threshold_scale=0):
//     short_preamble_detected pulses at least once within the 160-sample field.

Source files
------------

// File: rtl/stf_gen_pkg.sv
// Shared constants and the 802.11a/g short-training-symbol table for the STF generator.
// Table entries are round(8192 * s(k)) of the 16 time-domain short-symbol samples.
package stf_gen_pkg;

    localparam int unsigned STF_SYM_LEN = 16;
    localparam int unsigned IQ_WIDTH    = 16;
    localparam int unsigned SYM_IDX_W   = 4;

    typedef logic signed [IQ_WIDTH-1:0] iq_t;

    function automatic logic [2*IQ_WIDTH-1:0] stf_rom_word(input logic [SYM_IDX_W-1:0] idx);
        logic [2*IQ_WIDTH-1:0] word;
        case (idx)
            4'd0:    word = {iq_t'(377),   iq_t'(377)};
            4'd1:    word = {iq_t'(-1081), iq_t'(16)};
            4'd2:    word = {iq_t'(-106),  iq_t'(-647)};
            4'd3:    word = {iq_t'(1171),  iq_t'(-106)};
            4'd4:    word = {iq_t'(754),   iq_t'(0)};
            4'd5:    word = {iq_t'(1171),  iq_t'(-106)};
            4'd6:    word = {iq_t'(-106),  iq_t'(-647)};
            4'd7:    word = {iq_t'(-1081), iq_t'(16)};
            4'd8:    word = {iq_t'(377),   iq_t'(377)};
            4'd9:    word = {iq_t'(16),    iq_t'(-1081)};
            4'd10:   word = {iq_t'(-647),  iq_t'(-106)};
            4'd11:   word = {iq_t'(-106),  iq_t'(1171)};
            4'd12:   word = {iq_t'(0),     iq_t'(754)};
            4'd13:   word = {iq_t'(-106),  iq_t'(1171)};
            4'd14:   word = {iq_t'(-647),  iq_t'(-106)};
            default: word = {iq_t'(16),    iq_t'(-1081)};
        endcase
        return word;
    endfunction

endpackage

// File: rtl/stf_gen_rom.sv
// 16x32 registered short-symbol ROM: address in, {I,Q} word out one cycle later.
module stf_gen_rom
    import stf_gen_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic [SYM_IDX_W-1:0]  addr_i,
    output logic [2*IQ_WIDTH-1:0] data_o
);

    logic [2*IQ_WIDTH-1:0] data_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            data_q <= '0;
        end else if (enable_i) begin
            data_q <= stf_rom_word(addr_i);
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/stf_gen.sv
// 802.11a/g short training field generator: streams NumReps copies of the 16-sample
// short symbol as {I,Q} over a valid/ready interface, with gain shift and edge window.
module stf_gen
    import stf_gen_pkg::*;
#(
    parameter int unsigned NumReps  = 10,
    parameter bit          WindowEn = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  start_i,
    input  logic [1:0]            gain_shift_i,
    input  logic                  sample_out_ready_i,
    output logic [2*IQ_WIDTH-1:0] sample_out_o,
    output logic                  sample_out_strobe_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [3:0] LastRep = 4'(NumReps - 1);

    logic [1:0]           state_q, state_d;
    logic [SYM_IDX_W-1:0] sym_idx_q, sym_idx_d;
    logic [3:0]           rep_cnt_q, rep_cnt_d;
    logic [1:0]           gain_q, gain_d;
    logic [2*IQ_WIDTH-1:0] rom_data;
    logic                 xfer;

    assign sample_out_strobe_o = (state_q == StRun) && enable_i;
    assign xfer                = sample_out_strobe_o && sample_out_ready_i;
    assign busy_o              = (state_q == StRun);
    assign done_o              = (state_q == StDone);

    always_comb begin
        state_d   = state_q;
        sym_idx_d = sym_idx_q;
        rep_cnt_d = rep_cnt_q;
        gain_d    = gain_q;
        if (enable_i) begin
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        state_d   = StRun;
                        gain_d    = gain_shift_i;
                        sym_idx_d = '0;
                        rep_cnt_d = '0;
                    end
                end
                StRun: begin
                    if (xfer) begin
                        sym_idx_d = sym_idx_q + 4'd1;
                        if (sym_idx_q == 4'd15) begin
                            if (rep_cnt_q == LastRep) begin
                                state_d   = StDone;
                                rep_cnt_d = '0;
                            end else begin
                                rep_cnt_d = rep_cnt_q + 4'd1;
                            end
                        end
                    end
                end
                StDone: state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            sym_idx_q <= '0;
            rep_cnt_q <= '0;
            gain_q    <= '0;
        end else begin
            state_q   <= state_d;
            sym_idx_q <= sym_idx_d;
            rep_cnt_q <= rep_cnt_d;
            gain_q    <= gain_d;
        end
    end

    // ROM is addressed with the next index so the word lines up with the registered state.
    stf_gen_rom u_rom (
        .clock    (clock),
        .reset    (reset),
        .enable_i (enable_i),
        .addr_i   (sym_idx_d),
        .data_o   (rom_data)
    );

    iq_t rom_i, rom_q, gain_i, gain_q_c, out_i, out_q;
    logic first_sample;

    always_comb begin
        rom_i        = iq_t'(rom_data[31:16]);
        rom_q        = iq_t'(rom_data[15:0]);
        gain_i       = rom_i >>> gain_q;
        gain_q_c     = rom_q >>> gain_q;
        first_sample = WindowEn && (sym_idx_q == '0) && (rep_cnt_q == '0);
        out_i        = first_sample ? (gain_i >>> 1) : gain_i;
        out_q        = first_sample ? (gain_q_c >>> 1) : gain_q_c;
        sample_out_o = (state_q == StRun) ? {out_i, out_q} : '0;
    end

endmodule
